// File: rtl/shift_reg_pkg.sv
// shift_reg_pkg: mode encodings and count-width helper shared by the shift register blocks
package shift_reg_pkg;
  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/shift_reg_stage.sv
// shift_reg_stage: one data register plus valid bit with hold/left/right/load next-value mux
module shift_reg_stage
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] left_d,
  input  logic             left_v,
  input  logic [WIDTH-1:0] right_d,
  input  logic             right_v,
  input  logic [WIDTH-1:0] load_d,
  output logic [WIDTH-1:0] q,
  output logic             v
);
  logic [WIDTH-1:0] nd;
  logic             nv;
  // case with a hold default so an unknown sel leaves the stage untouched
  always_comb begin
    nd = q;
    nv = v;
    case (sel)
      MODE_SHR:  begin nd = left_d;  nv = left_v;  end
      MODE_SHL:  begin nd = right_d; nv = right_v; end
      MODE_LOAD: begin nd = load_d;  nv = 1'b1;    end
      default:   ;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      q <= RESET_VAL;
      v <= 1'b0;
    end else if (en) begin
      q <= nd;
      v <= nv;
    end
endmodule

// File: rtl/shift_reg_sync_reset.sv
// shift_reg_sync_reset: DEPTH-stage WIDTH-bit shift register with valid bits and occupancy count
// Optional SHIFT_REG_ROTATE_EN adds a rotate input that recirculates the end stage instead of d_in.
module shift_reg_sync_reset
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic [1:0]                mode,
`ifdef SHIFT_REG_ROTATE_EN
  input  logic                      rotate,
`endif
  input  logic [WIDTH-1:0]          d_in,
  input  logic                      d_in_vld,
  input  logic [WIDTH*DEPTH-1:0]    load_data,
  output logic [WIDTH-1:0]          q_out,
  output logic                      q_out_vld,
  output logic [WIDTH*DEPTH-1:0]    q_all,
  output logic [cnt_w(DEPTH)-1:0]   count,
  output logic                      full,
  output logic                      empty
);
  localparam int CW = cnt_w(DEPTH);
  logic [WIDTH-1:0] d [DEPTH];
  logic             v [DEPTH];
  logic             rot;
`ifdef SHIFT_REG_ROTATE_EN
  assign rot = rotate;
`else
  assign rot = 1'b0;
`endif
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic [WIDTH-1:0] ld, rd;
    logic             lv, rv;
    if (i == 0) begin : g_first
      assign ld = rot ? d[DEPTH-1] : d_in;
      assign lv = rot ? v[DEPTH-1] : d_in_vld;
    end else begin : g_mid_l
      assign ld = d[i-1];
      assign lv = v[i-1];
    end
    if (i == DEPTH-1) begin : g_last
      assign rd = rot ? d[0] : d_in;
      assign rv = rot ? v[0] : d_in_vld;
    end else begin : g_mid_r
      assign rd = d[i+1];
      assign rv = v[i+1];
    end
    shift_reg_stage #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_stage (
      .clk(clk), .reset(reset), .en(en), .sel(mode),
      .left_d(ld), .left_v(lv), .right_d(rd), .right_v(rv),
      .load_d(load_data[i*WIDTH +: WIDTH]), .q(d[i]), .v(v[i])
    );
    assign q_all[i*WIDTH +: WIDTH] = d[i];
  end
  assign q_out     = d[DEPTH-1];
  assign q_out_vld = v[DEPTH-1];
  always_comb begin
    count = '0;
    for (int i = 0; i < DEPTH; i++) count = count + CW'(v[i]);
  end
  assign full  = count == CW'(DEPTH);
  assign empty = count == '0;
endmodule

// File: tb/tb_shift_reg_sync_reset.sv
// tb_shift_reg_sync_reset: directed self-checking bench for shift_reg_sync_reset (WIDTH=8, DEPTH=4)
module tb_shift_reg_sync_reset;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic        rotate = 1'b0;
  logic [7:0]  d_in = 8'h00;
  logic        d_in_vld = 1'b0;
  logic [31:0] load_data = 32'h0;
  logic [7:0]  q_out;
  logic        q_out_vld;
  logic [31:0] q_all;
  logic [2:0]  count;
  logic        full, empty;
  int n_cmp = 0;
  int n_err = 0;

  shift_reg_sync_reset #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h00)) dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode),
`ifdef SHIFT_REG_ROTATE_EN
    .rotate(rotate),
`endif
    .d_in(d_in), .d_in_vld(d_in_vld), .load_data(load_data),
    .q_out(q_out), .q_out_vld(q_out_vld), .q_all(q_all),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_state(input string name, input logic [31:0] eq, input logic [2:0] ec);
    n_cmp++;
    if (q_all !== eq) begin n_err++; $display("FAIL %s q_all: got %h want %h", name, q_all, eq); end
    n_cmp++;
    if (count !== ec) begin n_err++; $display("FAIL %s count: got %0d want %0d", name, count, ec); end
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b0; mode = 2'b00;
    step(); step();
    chk_state("reset", 32'h0, 3'd0);
    n_cmp++;
    if (empty !== 1'b1) begin n_err++; $display("FAIL reset empty: got %b want 1", empty); end
    n_cmp++;
    if (full !== 1'b0) begin n_err++; $display("FAIL reset full: got %b want 0", full); end
    n_cmp++;
    if (q_out_vld !== 1'b0) begin n_err++; $display("FAIL reset q_out_vld: got %b want 0", q_out_vld); end
    reset = 1'b0;
  endtask

  task automatic test_shift_right();
    logic [7:0] vals [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    en = 1'b1; mode = 2'b01; d_in_vld = 1'b1;
    d_in = vals[0]; step();
    chk_state("shr1", 32'h000000A1, 3'd1);
    n_cmp++;
    if (q_out_vld !== 1'b0) begin n_err++; $display("FAIL shr1 q_out_vld: got %b want 0", q_out_vld); end
    for (int i = 1; i < 4; i++) begin d_in = vals[i]; step(); end
    chk_state("shr4", 32'hA1B2C3D4, 3'd4);
    n_cmp++;
    if (q_out !== 8'hA1) begin n_err++; $display("FAIL shr4 q_out: got %h want a1", q_out); end
    n_cmp++;
    if (full !== 1'b1) begin n_err++; $display("FAIL shr4 full: got %b want 1", full); end
    d_in = 8'hE5; d_in_vld = 1'b0; step();
    chk_state("shr5", 32'hB2C3D4E5, 3'd3);
    n_cmp++;
    if (q_out !== 8'hB2) begin n_err++; $display("FAIL shr5 q_out: got %h want b2", q_out); end
    n_cmp++;
    if (full !== 1'b0) begin n_err++; $display("FAIL shr5 full: got %b want 0", full); end
  endtask

  task automatic test_load_shift_left();
    mode = 2'b11; load_data = 32'h44332211; d_in = 8'hEE; d_in_vld = 1'b0; step();
    chk_state("load", 32'h44332211, 3'd4);
    mode = 2'b10; d_in = 8'h55; d_in_vld = 1'b1; step();
    chk_state("shl1", 32'h55443322, 3'd4);
    d_in = 8'h66; d_in_vld = 1'b0; step();
    chk_state("shl2", 32'h66554433, 3'd3);
    n_cmp++;
    if (q_out_vld !== 1'b0) begin n_err++; $display("FAIL shl2 q_out_vld: got %b want 0", q_out_vld); end
  endtask

  task automatic test_hold();
    en = 1'b0; mode = 2'b01;
    for (int i = 0; i < 5; i++) begin
      d_in = 8'(i * 8'h3C); d_in_vld = i[0]; step();
      chk_state("en0", 32'h66554433, 3'd3);
    end
    en = 1'b1; mode = 2'b00; d_in = 8'hFF; d_in_vld = 1'b1; step();
    chk_state("hold", 32'h66554433, 3'd3);
  endtask

  task automatic test_reset_mid_shift();
    mode = 2'b01; d_in = 8'h99; d_in_vld = 1'b1; step();
    chk_state("pre_rst", 32'h55443399, 3'd4);
    reset = 1'b1; d_in = 8'hAA; step();
    chk_state("mid_rst", 32'h0, 3'd0);
    n_cmp++;
    if (empty !== 1'b1) begin n_err++; $display("FAIL mid_rst empty: got %b want 1", empty); end
    reset = 1'b0; d_in = 8'h77; step();
    chk_state("post_rst", 32'h00000077, 3'd1);
    mode = 2'b11; load_data = 32'hDEADBEEF; step();
    reset = 1'b1; en = 1'b0; step();
    chk_state("rst_en0", 32'h0, 3'd0);
    reset = 1'b0; en = 1'b1;
  endtask

`ifdef SHIFT_REG_ROTATE_EN
  task automatic test_rotate();
    logic [31:0] exp_r [4] = '{32'h33221144, 32'h22114433, 32'h11443322, 32'h44332211};
    mode = 2'b11; load_data = 32'h44332211; rotate = 1'b1; step();
    chk_state("rot_load", 32'h44332211, 3'd4);
    mode = 2'b01; d_in = 8'hFF; d_in_vld = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_state("rot_r", exp_r[i], 3'd4);
    end
    mode = 2'b11; step();
    mode = 2'b10; step();
    chk_state("rot_l", 32'h11443322, 3'd4);
    rotate = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_shift_right();
    test_load_shift_left();
    test_hold();
    test_reset_mid_shift();
`ifdef SHIFT_REG_ROTATE_EN
    test_rotate();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
